// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the fetch PC; training happens at writeback.
module branch_predictor #(
    parameter int IDX_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_if,
    output logic        predict_taken_if,
    output logic [15:0] taken_pc_if,
    input  logic        update_valid_wb,
    input  logic [15:0] pc_wb,
    input  logic        actual_taken_wb,
    input  logic [15:0] actual_target_wb,
    input  logic        predict_taken_wb,
    input  logic [15:0] taken_pc_wb,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 15 - IDX_BITS;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [15:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [15:0]      r_branch_count;
    logic [15:0]      r_mispredict_count;

    logic [IDX_BITS-1:0] w_idx_if;
    logic [IDX_BITS-1:0] w_idx_wb;
    logic [TAG_W-1:0]    w_tag_if;
    logic [TAG_W-1:0]    w_tag_wb;
    logic                w_hit_if;
    logic                w_hit_wb;
    logic                w_mispredict;
    logic [1:0]          w_ctr_next;
    logic                w_unused;

    // pc[0] is always zero for aligned instructions and never indexes the table
    assign w_unused = ^{pc_if[0], pc_wb[0]};

    assign w_idx_if = pc_if[IDX_BITS:1];
    assign w_tag_if = pc_if[15:IDX_BITS+1];
    assign w_idx_wb = pc_wb[IDX_BITS:1];
    assign w_tag_wb = pc_wb[15:IDX_BITS+1];

    assign w_hit_if         = r_valid[w_idx_if] && (r_tag[w_idx_if] == w_tag_if);
    assign predict_taken_if = w_hit_if && r_ctr[w_idx_if][1];
    assign taken_pc_if      = predict_taken_if ? r_target[w_idx_if] : pc_if + 16'd2;

    assign w_hit_wb = r_valid[w_idx_wb] && (r_tag[w_idx_wb] == w_tag_wb);

    always_comb begin
        w_ctr_next = r_ctr[w_idx_wb];
        if (actual_taken_wb) begin
            if (w_ctr_next != 2'b11) begin
                w_ctr_next = w_ctr_next + 2'd1;
            end
        end else if (w_ctr_next != 2'b00) begin
            w_ctr_next = w_ctr_next - 2'd1;
        end
    end

    // A correctly-predicted taken branch still mispredicts if the target was stale
    assign w_mispredict = (predict_taken_wb != actual_taken_wb) ||
                          (predict_taken_wb && actual_taken_wb &&
                           (taken_pc_wb != actual_target_wb));

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        localparam logic [IDX_BITS-1:0] ENTRY_IDX = IDX_BITS'(g);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid[g]  <= 1'b0;
                r_tag[g]    <= '0;
                r_target[g] <= 16'h0000;
                r_ctr[g]    <= 2'b01;
            end else if (update_valid_wb && (w_idx_wb == ENTRY_IDX)) begin
                if (w_hit_wb) begin
                    r_ctr[g] <= w_ctr_next;
                    if (actual_taken_wb) begin
                        r_target[g] <= actual_target_wb;
                    end
                end else if (actual_taken_wb) begin
                    r_valid[g]  <= 1'b1;
                    r_tag[g]    <= w_tag_wb;
                    r_target[g] <= actual_target_wb;
                    r_ctr[g]    <= 2'b10;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_count     <= 16'h0000;
            r_mispredict_count <= 16'h0000;
        end else if (update_valid_wb) begin
            if (r_branch_count != 16'hFFFF) begin
                r_branch_count <= r_branch_count + 16'd1;
            end
            if (w_mispredict && (r_mispredict_count != 16'hFFFF)) begin
                r_mispredict_count <= r_mispredict_count + 16'd1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Scenario bench for branch_predictor: expectations are queued as stimulus is
// driven and compared against sampled outputs at the end of each scenario.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [15:0] pc_if;
    logic        predict_taken_if;
    logic [15:0] taken_pc_if;
    logic        update_valid_wb;
    logic [15:0] pc_wb;
    logic        actual_taken_wb;
    logic [15:0] actual_target_wb;
    logic        predict_taken_wb;
    logic [15:0] taken_pc_wb;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    typedef struct packed {
        logic        pred;
        logic [15:0] tpc;
        logic [15:0] bc;
        logic [15:0] mc;
    } sample_t;

    sample_t sb_exp[$];
    sample_t sb_obs[$];
    string   sb_name[$];
    int      n_cmp;
    int      n_bad;
    logic [15:0] m_bc;
    logic [15:0] m_mc;

    branch_predictor #(.IDX_BITS(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_if            (pc_if),
        .predict_taken_if (predict_taken_if),
        .taken_pc_if      (taken_pc_if),
        .update_valid_wb  (update_valid_wb),
        .pc_wb            (pc_wb),
        .actual_taken_wb  (actual_taken_wb),
        .actual_target_wb (actual_target_wb),
        .predict_taken_wb (predict_taken_wb),
        .taken_pc_wb      (taken_pc_wb),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_mispredict();
        return (predict_taken_wb != actual_taken_wb) ||
               (predict_taken_wb && actual_taken_wb && (taken_pc_wb != actual_target_wb));
    endfunction

    // Advance one edge, applying the performance-counter model to the inputs seen there
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_bc = 16'h0000;
            m_mc = 16'h0000;
        end else if (update_valid_wb) begin
            if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
            if (model_mispredict() && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
        end
        #1;
        update_valid_wb = 1'b0;
        reset           = 1'b0;
    endtask

    task automatic drive_wb(input logic [15:0] pc, input logic act, input logic [15:0] tgt,
                            input logic pwb, input logic [15:0] tpwb);
        update_valid_wb  = 1'b1;
        pc_wb            = pc;
        actual_taken_wb  = act;
        actual_target_wb = tgt;
        predict_taken_wb = pwb;
        taken_pc_wb      = tpwb;
    endtask

    task automatic look(input logic [15:0] pc, input string nm, input logic pred,
                        input logic [15:0] tpc, input logic [15:0] bc, input logic [15:0] mc);
        pc_if = pc;
        sb_exp.push_back('{pred: pred, tpc: tpc, bc: bc, mc: mc});
        sb_name.push_back(nm);
        #1;
        sb_obs.push_back('{pred: predict_taken_if, tpc: taken_pc_if, bc: branch_count,
                           mc: mispredict_count});
    endtask

    task automatic test_reset();
        sample_t e;
        sample_t o;
        string   nm;
        reset = 1'b1;
        tick();
        look(16'h3000, "reset_3000", 1'b0, 16'h3002, 16'h0000, 16'h0000);
        look(16'hFFFE, "reset_wrap", 1'b0, 16'h0000, 16'h0000, 16'h0000);
        look(16'h0001, "reset_odd", 1'b0, 16'h0003, 16'h0000, 16'h0000);
        while (sb_exp.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++; if (o.pred !== e.pred) begin n_bad++;
                $display("FAIL %s predict_taken_if: got %b want %b", nm, o.pred, e.pred); end
            n_cmp++; if (o.tpc !== e.tpc) begin n_bad++;
                $display("FAIL %s taken_pc_if: got %h want %h", nm, o.tpc, e.tpc); end
            n_cmp++; if (o.bc !== e.bc) begin n_bad++;
                $display("FAIL %s branch_count: got %h want %h", nm, o.bc, e.bc); end
            n_cmp++; if (o.mc !== e.mc) begin n_bad++;
                $display("FAIL %s mispredict_count: got %h want %h", nm, o.mc, e.mc); end
        end
    endtask

    task automatic test_counter();
        sample_t e;
        sample_t o;
        string   nm;
        drive_wb(16'h3000, 1'b1, 16'h3040, 1'b0, 16'h3002);
        tick();
        look(16'h3000, "alloc_hit", 1'b1, 16'h3040, 16'h0001, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            drive_wb(16'h3000, 1'b0, 16'h0000, 1'b1, 16'h3040);
            tick();
            look(16'h3000, $sformatf("not_taken_%0d", i), 1'b0, 16'h3002, m_bc, m_mc);
        end
        // From 00: one taken step must land on 01, not wrap
        drive_wb(16'h3000, 1'b1, 16'h3050, 1'b0, 16'h3002);
        tick();
        look(16'h3000, "taken_from_00", 1'b0, 16'h3002, m_bc, m_mc);
        drive_wb(16'h3000, 1'b1, 16'h3050, 1'b0, 16'h3002);
        tick();
        look(16'h3000, "taken_to_10", 1'b1, 16'h3050, m_bc, m_mc);
        drive_wb(16'h3000, 1'b1, 16'h3050, 1'b1, 16'h3050);
        tick();
        look(16'h3000, "correct_no_mp", 1'b1, 16'h3050, 16'h0007, 16'h0006);
        drive_wb(16'h3000, 1'b1, 16'h3060, 1'b1, 16'h3050);
        tick();
        look(16'h3000, "wrong_target", 1'b1, 16'h3060, 16'h0008, 16'h0007);
        drive_wb(16'h3000, 1'b0, 16'h0000, 1'b1, 16'h3060);
        tick();
        look(16'h3000, "sat_11_then_nt", 1'b1, 16'h3060, m_bc, m_mc);
        while (sb_exp.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++; if (o.pred !== e.pred) begin n_bad++;
                $display("FAIL %s predict_taken_if: got %b want %b", nm, o.pred, e.pred); end
            n_cmp++; if (o.tpc !== e.tpc) begin n_bad++;
                $display("FAIL %s taken_pc_if: got %h want %h", nm, o.tpc, e.tpc); end
            n_cmp++; if (o.bc !== e.bc) begin n_bad++;
                $display("FAIL %s branch_count: got %h want %h", nm, o.bc, e.bc); end
            n_cmp++; if (o.mc !== e.mc) begin n_bad++;
                $display("FAIL %s mispredict_count: got %h want %h", nm, o.mc, e.mc); end
        end
    endtask

    task automatic test_alias();
        sample_t e;
        sample_t o;
        string   nm;
        look(16'h3010, "alias_miss", 1'b0, 16'h3012, m_bc, m_mc);
        drive_wb(16'h3010, 1'b1, 16'h3100, 1'b0, 16'h3012);
        tick();
        look(16'h3010, "alias_new", 1'b1, 16'h3100, m_bc, m_mc);
        look(16'h3000, "alias_old_gone", 1'b0, 16'h3002, m_bc, m_mc);
        drive_wb(16'h3000, 1'b0, 16'h0000, 1'b0, 16'h3002);
        tick();
        look(16'h3010, "miss_nt_keeps", 1'b1, 16'h3100, m_bc, m_mc);
        while (sb_exp.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++; if (o.pred !== e.pred) begin n_bad++;
                $display("FAIL %s predict_taken_if: got %b want %b", nm, o.pred, e.pred); end
            n_cmp++; if (o.tpc !== e.tpc) begin n_bad++;
                $display("FAIL %s taken_pc_if: got %h want %h", nm, o.tpc, e.tpc); end
            n_cmp++; if (o.bc !== e.bc) begin n_bad++;
                $display("FAIL %s branch_count: got %h want %h", nm, o.bc, e.bc); end
            n_cmp++; if (o.mc !== e.mc) begin n_bad++;
                $display("FAIL %s mispredict_count: got %h want %h", nm, o.mc, e.mc); end
        end
    endtask

    task automatic test_same_cycle();
        sample_t e;
        sample_t o;
        string   nm;
        drive_wb(16'h3010, 1'b0, 16'h0000, 1'b1, 16'h3100);
        look(16'h3010, "same_cycle_old", 1'b1, 16'h3100, m_bc, m_mc);
        tick();
        look(16'h3010, "same_cycle_new", 1'b0, 16'h3012, m_bc, m_mc);
        drive_wb(16'h3000, 1'b1, 16'h3200, 1'b0, 16'h3002);
        look(16'h3000, "alloc_same_old", 1'b0, 16'h3002, m_bc, m_mc);
        tick();
        look(16'h3000, "alloc_same_new", 1'b1, 16'h3200, m_bc, m_mc);
        while (sb_exp.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++; if (o.pred !== e.pred) begin n_bad++;
                $display("FAIL %s predict_taken_if: got %b want %b", nm, o.pred, e.pred); end
            n_cmp++; if (o.tpc !== e.tpc) begin n_bad++;
                $display("FAIL %s taken_pc_if: got %h want %h", nm, o.tpc, e.tpc); end
            n_cmp++; if (o.bc !== e.bc) begin n_bad++;
                $display("FAIL %s branch_count: got %h want %h", nm, o.bc, e.bc); end
            n_cmp++; if (o.mc !== e.mc) begin n_bad++;
                $display("FAIL %s mispredict_count: got %h want %h", nm, o.mc, e.mc); end
        end
    endtask

    task automatic test_reset_priority();
        sample_t e;
        sample_t o;
        string   nm;
        reset = 1'b1;
        drive_wb(16'h3006, 1'b1, 16'h3300, 1'b0, 16'h3008);
        tick();
        look(16'h3006, "rst_upd_discard", 1'b0, 16'h3008, 16'h0000, 16'h0000);
        look(16'h3000, "rst_clears", 1'b0, 16'h3002, 16'h0000, 16'h0000);
        while (sb_exp.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++; if (o.pred !== e.pred) begin n_bad++;
                $display("FAIL %s predict_taken_if: got %b want %b", nm, o.pred, e.pred); end
            n_cmp++; if (o.tpc !== e.tpc) begin n_bad++;
                $display("FAIL %s taken_pc_if: got %h want %h", nm, o.tpc, e.tpc); end
            n_cmp++; if (o.bc !== e.bc) begin n_bad++;
                $display("FAIL %s branch_count: got %h want %h", nm, o.bc, e.bc); end
            n_cmp++; if (o.mc !== e.mc) begin n_bad++;
                $display("FAIL %s mispredict_count: got %h want %h", nm, o.mc, e.mc); end
        end
    endtask

    task automatic test_saturation();
        sample_t e;
        sample_t o;
        string   nm;
        for (int i = 0; i < 65536; i++) begin
            drive_wb(16'h4000, 1'b0, 16'h0000, 1'b1, 16'h4000);
            tick();
            if (i == 999) look(16'h4000, "sat_1000", 1'b0, 16'h4002, 16'd1000, 16'd1000);
        end
        look(16'h4000, "sat_hold", 1'b0, 16'h4002, 16'hFFFF, 16'hFFFF);
        drive_wb(16'h4000, 1'b1, 16'h4040, 1'b1, 16'h4040);
        tick();
        look(16'h4000, "sat_correct", 1'b1, 16'h4040, 16'hFFFF, 16'hFFFF);
        while (sb_exp.size() != 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++; if (o.pred !== e.pred) begin n_bad++;
                $display("FAIL %s predict_taken_if: got %b want %b", nm, o.pred, e.pred); end
            n_cmp++; if (o.tpc !== e.tpc) begin n_bad++;
                $display("FAIL %s taken_pc_if: got %h want %h", nm, o.tpc, e.tpc); end
            n_cmp++; if (o.bc !== e.bc) begin n_bad++;
                $display("FAIL %s branch_count: got %h want %h", nm, o.bc, e.bc); end
            n_cmp++; if (o.mc !== e.mc) begin n_bad++;
                $display("FAIL %s mispredict_count: got %h want %h", nm, o.mc, e.mc); end
        end
    endtask

    initial begin
        n_cmp            = 0;
        n_bad            = 0;
        m_bc             = 16'h0000;
        m_mc             = 16'h0000;
        reset            = 1'b1;
        pc_if            = 16'h0000;
        update_valid_wb  = 1'b0;
        pc_wb            = 16'h0000;
        actual_taken_wb  = 1'b0;
        actual_target_wb = 16'h0000;
        predict_taken_wb = 1'b0;
        taken_pc_wb      = 16'h0000;
        test_reset();
        test_counter();
        test_alias();
        test_same_cycle();
        test_reset_priority();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one parameter: IDX_BITS, default 3, log2 of table entry count (8 entries); legal range 1..6.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc_if  input  16 (lc3b_word)  fetch-stage PC being looked up.
REQ-005 predict_taken_if  output  1  prediction for pc_if; 1 = predicted taken.
REQ-006 taken_pc_if  output  16  next fetch PC: stored target when predicted taken, else pc_if+2.
REQ-007 update_valid_wb  input  1  WB stage retires a branch this cycle; all *_wb inputs are qualified by it.
REQ-008 pc_wb  input  16  PC of the retiring branch.
REQ-009 actual_taken_wb  input  1  resolved direction of the retiring branch.
REQ-010 actual_target_wb  input  16  resolved target (meaningful only when actual_taken_wb=1).
REQ-011 predict_taken_wb, taken_pc_wb  input  1, 16  prediction carried down the pipe for the retiring branch.
REQ-012 branch_count, mispredict_count  output  16 each  performance counters.

Function
REQ-013 Table: 2^IDX_BITS entries, each holding valid (1b), tag (pc[15:IDX_BITS+1]), target (16b), counter (2b).
REQ-014 Index SHALL be pc[IDX_BITS:1]; pc[0] ignored.
REQ-015 Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-016 Lookup SHALL be combinational, zero latency: hit = valid & tag match; predict_taken_if = hit & counter[1].
REQ-017 taken_pc_if SHALL equal entry target when predict_taken_if=1, else pc_if+2 (16-bit wrap, 0xFFFE+2 = 0x0000).
REQ-018 Update SHALL occur only on a clock edge with update_valid_wb=1; no update otherwise.
REQ-019 Update on hit: counter increments (saturating at 11) if actual_taken_wb=1, else decrements (saturating at 00); target overwritten with actual_target_wb only when actual_taken_wb=1.
REQ-020 Update on miss with actual_taken_wb=1: allocate/overwrite entry: valid=1, tag, target=actual_target_wb, counter=10.
REQ-021 Update on miss with actual_taken_wb=0: table unchanged.
REQ-022 Same-cycle lookup and update to the same entry: lookup SHALL return pre-edge state (no bypass); new state visible from the next cycle.
REQ-023 branch_count SHALL increment by 1 per update_valid_wb cycle, saturating at 0xFFFF.
REQ-024 Mispredict = predict_taken_wb != actual_taken_wb, OR (both 1 AND taken_pc_wb != actual_target_wb).
REQ-025 mispredict_count SHALL increment by 1 on each update_valid_wb cycle with mispredict, saturating at 0xFFFF.
REQ-026 Counters and table SHALL be registered; no combinational path from *_wb inputs to predict_taken_if/taken_pc_if.

Reset
REQ-027 reset=1 at a rising edge SHALL clear all valid bits, set all counters to 01, targets and tags to 0x0000, both performance counters to 0.
REQ-028 reset SHALL take priority over a simultaneous update_valid_wb; that update is discarded.
REQ-029 After reset, predict_taken_if=0 and taken_pc_if=pc_if+2 for every pc_if.

Verification
REQ-030 Reset, pc_if=0x3000 -> predict_taken_if=0, taken_pc_if=0x3002, counts 0.
REQ-031 Update pc_wb=0x3000, actual_taken=1, target=0x3040, predict_taken_wb=0 -> next cycle pc_if=0x3000 gives predict=1, taken_pc_if=0x3040; branch_count=1, mispredict_count=1.
REQ-032 Same entry, then two not-taken updates -> counter 10->01->00; predict_taken_if=0 after first; taken_pc_if=0x3002; a further not-taken keeps 00.
REQ-033 Alias: allocate 0x3000 taken, then pc_if=0x3010 (same index, different tag) -> predict=0; taken update at 0x3010 replaces entry, 0x3000 then misses.
REQ-034 Update and lookup of 0x3000 in same cycle -> lookup reflects old state; reset asserted with update_valid_wb=1 -> table cleared, counts 0.
REQ-035 Drive 0x10000 updates with mispredict every cycle -> both counters hold at 0xFFFF; predicted-taken correct target with correct direction -> mispredict_count unchanged.
